// File: rtl/bram_logger_mc.sv
// Multi-channel BRAM capture logger.
// Captures N_CH parallel channels into per-channel block RAMs, with optional
// decimation, in either one-shot fill or circular pre-trigger mode. Readout
// addresses are relative to the oldest stored sample (2-cycle read latency).
module bram_logger_mc #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  parameter int N_CH      = 2,
  parameter int DEC_W     = 8,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int NW = $clog2(RAM_DEPTH + 1),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_run_log,
  input  logic                      i_mode,
  input  logic [DEC_W-1:0]          i_decim,
  input  logic [AW-1:0]             i_post_count,
  input  logic                      i_trigger,
  input  logic                      i_valid,
  input  logic [N_CH*RAM_WIDTH-1:0] i_data_tx_to_mem,
  input  logic                      i_read_log,
  input  logic [CW-1:0]             i_ch_sel,
  input  logic [AW-1:0]             i_addr_log_to_mem,
  output logic [RAM_WIDTH-1:0]      o_data_log_from_mem,
  output logic                      o_data_valid,
  output logic                      o_mem_full,
  output logic                      o_busy,
  output logic [NW-1:0]             o_n_samples,
  output logic [AW-1:0]             o_trig_addr
);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ARMED, S_POST, S_FULL} state_t;
  state_t state, state_next;

  logic             mode;
  logic [DEC_W-1:0] decim, dec_cnt;
  logic [AW-1:0]    post_len, post_left, wr_ptr, trig_ptr, start_addr;
  logic [NW-1:0]    count;
  logic             wrapped;

  logic             capturing, start_run, accept, load_trig, enter_full;
  logic [AW-1:0]    wr_ptr_next, trig_next, start_next;
  logic [NW-1:0]    count_next;
  logic             wrapped_next;

  logic [AW-1:0]    rd_addr;
  logic [CW-1:0]    rd_sel, out_sel;
  logic             rd_pend;
  logic [RAM_WIDTH-1:0] dout [N_CH];

  assign capturing = (state == S_CAPTURE) || (state == S_ARMED) || (state == S_POST);
  assign start_run = ((state == S_IDLE) || (state == S_FULL)) && i_run_log;
  assign accept    = capturing && i_valid && (dec_cnt == '0);
  assign o_busy    = capturing;

  // Values the capture registers take this cycle; FULL entry snapshots them.
  assign wr_ptr_next  = accept ? wr_ptr + 1'b1 : wr_ptr;
  assign wrapped_next = wrapped | (accept && (state != S_CAPTURE) && (wr_ptr == AW'(RAM_DEPTH - 1)));
  assign count_next   = (accept && (count != NW'(RAM_DEPTH))) ? count + 1'b1 : count;
  assign trig_next    = load_trig ? wr_ptr : trig_ptr;
  assign start_next   = wrapped_next ? wr_ptr_next : '0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; the trigger-cycle sample counts toward the post length.
  always_comb begin
    state_next = state;
    load_trig  = 1'b0;
    enter_full = 1'b0;
    case (state)
      S_IDLE, S_FULL: begin
        if (i_run_log) state_next = i_mode ? S_ARMED : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (accept && (count == NW'(RAM_DEPTH - 1))) begin
          state_next = S_FULL;
          enter_full = 1'b1;
        end
      end
      S_ARMED: begin
        if (i_trigger) begin
          load_trig = 1'b1;
          if ((post_len == '0) || (accept && (post_len == AW'(1)))) begin
            state_next = S_FULL;
            enter_full = 1'b1;
          end else begin
            state_next = S_POST;
          end
        end
      end
      S_POST: begin
        if (accept && (post_left == AW'(1))) begin
          state_next = S_FULL;
          enter_full = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture bookkeeping: run latching, pointers, counters and FULL snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode        <= 1'b0;
      decim       <= '0;
      post_len    <= '0;
      dec_cnt     <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      wrapped     <= 1'b0;
      trig_ptr    <= '0;
      post_left   <= '0;
      start_addr  <= '0;
      o_n_samples <= '0;
      o_trig_addr <= '0;
      o_mem_full  <= 1'b0;
    end else if (start_run) begin
      mode       <= i_mode;
      decim      <= i_decim;
      post_len   <= i_post_count;
      dec_cnt    <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wrapped    <= 1'b0;
      trig_ptr   <= '0;
      post_left  <= '0;
      o_mem_full <= 1'b0;
    end else if (capturing) begin
      if (i_valid) dec_cnt <= (dec_cnt == decim) ? '0 : dec_cnt + 1'b1;
      wr_ptr   <= wr_ptr_next;
      wrapped  <= wrapped_next;
      count    <= count_next;
      trig_ptr <= trig_next;
      if (load_trig)                   post_left <= post_len - AW'(accept);
      else if (state == S_POST && accept) post_left <= post_left - 1'b1;
      if (enter_full) begin
        start_addr  <= start_next;
        o_n_samples <= wrapped_next ? NW'(RAM_DEPTH) : count_next;
        o_trig_addr <= trig_next - start_next;
        o_mem_full  <= 1'b1;
      end
    end
  end

  // Read pipeline: stage 1 registers the physical address, stage 2 the data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend      <= 1'b0;
      rd_addr      <= '0;
      rd_sel       <= '0;
      out_sel      <= '0;
      o_data_valid <= 1'b0;
    end else begin
      rd_pend <= (state == S_FULL) && i_read_log;
      if ((state == S_FULL) && i_read_log) begin
        rd_addr <= start_addr + i_addr_log_to_mem;
        rd_sel  <= i_ch_sel;
      end
      o_data_valid <= rd_pend;
      if (rd_pend) out_sel <= rd_sel;
    end
  end

  // One block RAM per channel, written together, read with a registered output.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Sample write.
    always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= i_data_tx_to_mem[gi*RAM_WIDTH +: RAM_WIDTH];
    end

    // Registered read; holds between reads.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       dout[gi] <= '0;
      else if (rd_pend) dout[gi] <= mem[rd_addr];
    end
  end

  // Channel select; an out-of-range channel reads as zero.
  always_comb begin
    o_data_log_from_mem = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (out_sel == CW'(k)) o_data_log_from_mem = dout[k];
    end
  end

endmodule

// File: tb/tb_bram_logger_mc.sv
// Self-checking bench for bram_logger_mc: a queue-based model of the stored
// sample stream predicts busy/full every cycle, the FULL snapshot and reads.
module tb_bram_logger_mc;
  localparam int W = 18, D = 1024, NC = 2, DW = 8, AW = 10, NW = 11;

  logic clk = 1'b0, reset = 1'b0;
  logic i_run_log = 0, i_mode = 0, i_trigger = 0, i_valid = 0, i_read_log = 0;
  logic [DW-1:0] i_decim = '0;
  logic [AW-1:0] i_post_count = '0, i_addr_log_to_mem = '0;
  logic [NC*W-1:0] i_data_tx_to_mem = '0;
  logic [0:0] i_ch_sel = '0;
  logic [W-1:0] o_data_log_from_mem;
  logic o_data_valid, o_mem_full, o_busy;
  logic [NW-1:0] o_n_samples;
  logic [AW-1:0] o_trig_addr;

  bram_logger_mc #(.RAM_WIDTH(W), .RAM_DEPTH(D), .N_CH(NC), .DEC_W(DW)) dut (
    .clk(clk), .reset(reset), .i_run_log(i_run_log), .i_mode(i_mode),
    .i_decim(i_decim), .i_post_count(i_post_count), .i_trigger(i_trigger),
    .i_valid(i_valid), .i_data_tx_to_mem(i_data_tx_to_mem),
    .i_read_log(i_read_log), .i_ch_sel(i_ch_sel),
    .i_addr_log_to_mem(i_addr_log_to_mem),
    .o_data_log_from_mem(o_data_log_from_mem), .o_data_valid(o_data_valid),
    .o_mem_full(o_mem_full), .o_busy(o_busy), .o_n_samples(o_n_samples),
    .o_trig_addr(o_trig_addr));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: every accepted sample since the last run, in arrival order.
  int q0[$], q1[$];
  bit m_active = 0, m_full = 0, m_mode = 0, m_armed = 0;
  int m_decim = 0, m_post = 0, m_vcnt = 0, m_tidx = 0;
  int m_n = 0, m_t = 0, m_oldest = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},  32'(o_data_log_from_mem), 0);
    chk({tag, "_valid"}, 32'(o_data_valid), 0);
    chk({tag, "_full"},  32'(o_mem_full), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_n"},     32'(o_n_samples), 0);
    chk({tag, "_trig"},  32'(o_trig_addr), 0);
  endtask

  // Apply one clock edge's worth of inputs to the model.
  task automatic model_edge(input bit v, input bit trg, input bit run, input int d0, input int d1);
    bit acc, done;
    if (!m_active) begin
      if (run) begin
        q0.delete(); q1.delete();
        m_vcnt = 0; m_mode = i_mode; m_decim = int'(i_decim); m_post = int'(i_post_count);
        m_armed = i_mode; m_full = 0; m_active = 1;
      end
    end else begin
      acc = v && ((m_vcnt % (m_decim + 1)) == 0);
      if (v) m_vcnt++;
      if (acc) begin q0.push_back(d0); q1.push_back(d1); end
      done = 0;
      if (!m_mode) done = (q0.size() == D);
      else if (m_armed) begin
        if (trg) begin
          m_armed = 0;
          m_tidx = q0.size() - int'(acc);
          done = (q0.size() >= m_tidx + m_post);
        end
      end else done = (q0.size() >= m_tidx + m_post);
      if (done) begin
        m_active = 0; m_full = 1;
        m_n = (q0.size() < D) ? q0.size() : D;
        m_oldest = q0.size() - m_n;
        m_t = m_mode ? ((m_tidx - m_oldest) % D) : 0;
      end
    end
  endtask

  task automatic cycle(input bit v, input bit trg, input bit run, input int d0, input int d1);
    @(negedge clk);
    i_valid = v; i_trigger = trg; i_run_log = run;
    i_data_tx_to_mem = {d1[W-1:0], d0[W-1:0]};
    @(posedge clk);
    model_edge(v, trg, run, d0 % (1 << W), d1 % (1 << W));
    #1;
    chk("busy", 32'(o_busy), 32'(m_active));
    chk("full", 32'(o_mem_full), 32'(m_full));
  endtask

  task automatic start(input bit mode, input int dec, input int post, input bit trg);
    i_mode = mode; i_decim = DW'(dec); i_post_count = AW'(post);
    cycle(0, trg, 1, 0, 0);
    i_run_log = 0; i_trigger = 0;
  endtask

  // Feed samples until the model says FULL; spurious run/trigger pulses are mixed in.
  task automatic fill(input int limit, input int vpct, input int trig_at, input bit pat);
    bit v, trg, run;
    int d0, d1;
    for (int c = 0; c < limit; c++) begin
      if (m_full) break;
      v = ($urandom_range(0, 99) < vpct);
      if (m_armed) trg = (q0.size() == trig_at);
      else         trg = ($urandom_range(0, 99) < 3);
      run = ($urandom_range(0, 99) < 2);
      if (pat) begin d0 = q0.size(); d1 = 1000 + q0.size(); end
      else begin d0 = int'($urandom_range(0, (1 << W) - 1)); d1 = int'($urandom_range(0, (1 << W) - 1)); end
      cycle(v, trg, run, d0, d1);
    end
    cycle(0, 0, 0, 0, 0);
    chk("capture_done", 32'(o_mem_full), 1);
    chk("n_samples", 32'(o_n_samples), 32'(m_n));
    chk("trig_addr", 32'(o_trig_addr), 32'(m_t));
  endtask

  task automatic read_one(input int ch, input int a);
    int e;
    e = ch ? q1[m_oldest + a] : q0[m_oldest + a];
    @(negedge clk);
    i_read_log = 1; i_ch_sel = ch[0:0]; i_addr_log_to_mem = a[AW-1:0];
    @(posedge clk); #1;
    chk("rd_edge1_valid", 32'(o_data_valid), 0);
    @(negedge clk); i_read_log = 0;
    @(posedge clk); #1;
    chk("rd_valid", 32'(o_data_valid), 1);
    chk("rd_data", 32'(o_data_log_from_mem), 32'(e));
    $display("[TB] read ch%0d addr %0d -> %0d (expect %0d)", ch, a, o_data_log_from_mem, e);
  endtask

  // Back-to-back random reads; each result appears two edges after its request.
  task automatic read_burst(input int n);
    int e_prev = 0, e = 0, ch, a;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i < n) begin
        ch = $urandom_range(0, 1); a = $urandom_range(0, m_n - 1);
        e = ch ? q1[m_oldest + a] : q0[m_oldest + a];
        i_read_log = 1; i_ch_sel = ch[0:0]; i_addr_log_to_mem = a[AW-1:0];
      end else i_read_log = 0;
      @(posedge clk); #1;
      if (i > 0) begin
        chk("burst_valid", 32'(o_data_valid), 1);
        chk("burst_data", 32'(o_data_log_from_mem), 32'(e_prev));
      end
      e_prev = e;
    end
    @(posedge clk); #1;
    chk("burst_end_valid", 32'(o_data_valid), 0);
    chk("burst_hold", 32'(o_data_log_from_mem), 32'(e_prev));
  endtask

  task automatic read_ignored(input string tag);
    @(negedge clk); i_read_log = 1; i_addr_log_to_mem = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk(tag, 32'(o_data_valid), 0);
    end
    @(negedge clk); i_read_log = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1;
    @(posedge clk); #1;
    check_zero("post_reset");
    read_ignored("idle_read");

    // Circular mode; run and trigger together in IDLE must only arm.
    start(1, 0, 100, 1);
    $display("[TB] circular run, post 100, trigger at sample 2000");
    fill(3000, 100, 2000, 0);
    read_one(0, 0); read_one(1, D - 1); read_one(0, m_t);
    read_burst(12);

    // One-shot fill with the n / 1000+n pattern; runs during capture ignored.
    start(0, 0, 0, 0);
    $display("[TB] one-shot fill, decim 0");
    fill(1500, 100, 0, 1);
    chk("a_n_1024", 32'(o_n_samples), 32'(D));
    read_one(0, 31); read_one(1, 31);
    read_burst(8);

    // One-shot fill with decimation 3.
    start(0, 3, 0, 0);
    $display("[TB] one-shot fill, decim 3");
    fill(5000, 100, 0, 1);
    read_one(0, 5); read_one(0, D - 1);
    read_burst(8);

    // Circular, short post length, no wrap.
    start(1, 0, 10, 0);
    $display("[TB] circular run, post 10, trigger at sample 50");
    fill(200, 100, 50, 1);
    chk("d_n_60", 32'(o_n_samples), 60);
    chk("d_trig_50", 32'(o_trig_addr), 50);
    read_one(0, 0);
    read_burst(8);

    // Trigger with zero post length and nothing captured yet.
    start(1, 0, 0, 0);
    $display("[TB] circular run, post 0, immediate trigger");
    fill(20, 0, 0, 0);

    // Circular, random valids and decimation, wraps.
    start(1, 2, 300, 0);
    $display("[TB] circular run, decim 2, random valids");
    fill(8000, 60, 1200, 0);
    read_burst(16);

    // Reset in the middle of the post-trigger phase.
    start(1, 0, 200, 0);
    for (int c = 0; c < 100; c++)
      cycle(1, c == 60, 0, int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)));
    chk("mid_post_busy", 32'(o_busy), 1);
    @(negedge clk); reset = 0; #1;
    check_zero("mid_post_reset");
    m_active = 0; m_full = 0; m_armed = 0; m_n = 0; m_t = 0;
    @(negedge clk); reset = 1;
    read_ignored("after_reset_read");
    start(0, 1, 0, 0);
    $display("[TB] one-shot fill after reset, decim 1");
    fill(5000, 70, 0, 0);
    read_burst(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
